// File: rtl/brisc_hazard_unit.sv
// brisc_hazard_unit: RAW hazard / forwarding / flush controller sitting beside decode.
// Latency: issue/stall/flush/fwd_*_sel are combinational (0 cycles); table and counters update every CLK edge.
// Backpressure: stall holds PC + decode register, flush squashes fetch/decode, and flush overrides stall.
// Ports:
//   CLK, RST_N                 clock, synchronous active-low reset
//   id_valid/ra/rb/rd/...      decoded instruction: sources with use flags, destination, write/load flags
//   ex_jump_en                 taken jump resolved in execute (stage 1)
//   issue, stall, flush        per-cycle decode control
//   fwd_a_sel, fwd_b_sel       operand source: 0 = regfile, k = result held in stage k
//   stall_cnt, flush_cnt       saturating debug counters
module brisc_hazard_unit #(
  parameter int RA_W      = 4,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 1,
  parameter int ZERO_REG  = 1,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_ra,
  input  logic             id_ra_used,
  input  logic [RA_W-1:0]  id_rb,
  input  logic             id_rb_used,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             ex_jump_en,
  output logic             issue,
  output logic             stall,
  output logic             flush,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int FC_W = $clog2(FLUSH_CYC + 1);

  // In-flight table, index k = stage k (1 = execute ... DEPTH = writeback).
  logic [DEPTH:1] t_vld;
  logic [DEPTH:1] t_wr;
  logic [DEPTH:1] t_ld;
  logic [RA_W-1:0] t_rd [1:DEPTH];

  logic [FC_W-1:0] flush_left;

  logic [SEL_W-1:0] hit_a;
  logic [SEL_W-1:0] hit_b;
  logic             haz_stall;
  logic             flush_i;
  logic             stall_i;
  logic             issue_i;

  // Youngest matching stage wins: scan oldest to youngest so the lowest k overwrites.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_ra_used && !(ZERO_REG != 0 && id_ra == '0) &&
          t_vld[k] && t_wr[k] && t_rd[k] == id_ra)
        hit_a = SEL_W'(k);
      if (id_rb_used && !(ZERO_REG != 0 && id_rb == '0) &&
          t_vld[k] && t_wr[k] && t_rd[k] == id_rb)
        hit_b = SEL_W'(k);
    end
  end

  always_comb begin
    haz_stall = 1'b0;
    if (FWD_EN != 0) begin
      // A load result is not available to forward from execute: only the k=1 load match stalls.
      haz_stall = (hit_a == SEL_W'(1) && t_ld[1]) || (hit_b == SEL_W'(1) && t_ld[1]);
    end else begin
      haz_stall = (hit_a != '0) || (hit_b != '0);
    end
  end

  assign flush_i = ex_jump_en || (flush_left != '0);
  assign stall_i = id_valid && haz_stall && !flush_i;
  assign issue_i = id_valid && !haz_stall && !flush_i;

  // Outputs are held inactive while reset is asserted.
  assign issue     = RST_N && issue_i;
  assign stall     = RST_N && stall_i;
  assign flush     = RST_N && flush_i;
  assign fwd_a_sel = (RST_N && FWD_EN != 0) ? hit_a : '0;
  assign fwd_b_sel = (RST_N && FWD_EN != 0) ? hit_b : '0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      t_vld      <= '0;
      t_wr       <= '0;
      t_ld       <= '0;
      for (int k = 1; k <= DEPTH; k++) t_rd[k] <= '0;
      flush_left <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      // The table advances every cycle regardless of stall; a stall inserts a bubble at stage 1.
      for (int k = DEPTH; k >= 2; k--) begin
        t_vld[k] <= t_vld[k-1];
        t_wr[k]  <= t_wr[k-1];
        t_ld[k]  <= t_ld[k-1];
        t_rd[k]  <= t_rd[k-1];
      end
      t_vld[1] <= issue;
      t_wr[1]  <= issue && id_reg_write;
      t_ld[1]  <= issue && id_is_load;
      t_rd[1]  <= id_rd;

      // A new jump restarts the window even if one is already running.
      if (ex_jump_en)
        flush_left <= FC_W'(FLUSH_CYC - 1);
      else if (flush_left != '0)
        flush_left <= flush_left - FC_W'(1);

      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
